// File: rtl/filter_pkg.sv
// filter_pkg: shared types, defaults and helpers for the Filter decoder slice
package filter_pkg;
  localparam int DEF_DATA_W = 16;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  parity;
  } filter_word_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/filter_unstage.sv
// filter_unstage: inverts one Filter stage (shift right, restore MSB from delayed parity)
// Ports: clk/reset (async active-low); data_in/valid_in/parity_in from the stage output;
// data_out/valid_out/parity_out feed the next unstage toward the original word.
module filter_unstage import filter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              parity_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              parity_out
);
  logic par_q;
  // The encoder emits a word's MSB as parity one cycle before the shifted word,
  // so it is captured every cycle regardless of valid.
  always_ff @(posedge clk or negedge reset)
    if (!reset) par_q <= 1'b0;
    else par_q <= parity_in;
  assign data_out   = {par_q, data_in[DATA_W-1:1]};
  assign parity_out = data_in[0];
  assign valid_out  = valid_in;
endmodule

// File: rtl/filter_decoder.sv
// filter_decoder: undoes STAGES Filter stages and buffers recovered words in a ready/valid FIFO
// Ports: clk/reset (async active-low); io_x_* from the last Filter stage;
// io_y_* FIFO head with io_y_ready pop; io_overflow sticky drop flag; io_level occupancy.
module filter_decoder import filter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STAGES = 2,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    io_x_data,
  input  logic                 io_x_valid,
  input  logic                 io_x_parity,
  output logic [DATA_W-1:0]    io_y_data,
  output logic                 io_y_parity,
  output logic                 io_y_valid,
  input  logic                 io_y_ready,
  output logic                 io_overflow,
  output logic [clog2(DEPTH):0] io_level
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(STAGES + 2);
  localparam logic [CW-1:0] WARM = CW'(STAGES + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  logic [DATA_W-1:0] d [STAGES+1];
  logic v [STAGES+1];
  logic p [STAGES+1];
  logic [CW-1:0] cnt;
  logic [AW:0] wr, rd;
  logic [DATA_W:0] mem [DEPTH];
  logic warm, full, pop, push_req, push;
  assign d[0] = io_x_data;
  assign v[0] = io_x_valid;
  assign p[0] = io_x_parity;
  // Instance 0 faces the last Filter stage, so the chain unwinds in reverse order.
  for (genvar i = 0; i < STAGES; i++) begin : g_un
    filter_unstage #(.DATA_W(DATA_W)) u (
      .clk(clk), .reset(reset),
      .data_in(d[i]), .valid_in(v[i]), .parity_in(p[i]),
      .data_out(d[i+1]), .valid_out(v[i+1]), .parity_out(p[i+1])
    );
  end
  // Chain output is garbage until every par_q and encoder register has been refilled.
  assign warm       = cnt == WARM;
  assign io_level   = wr - rd;
  assign io_y_valid = wr != rd;
  assign full       = io_level == FULL_LVL;
  assign pop        = io_y_valid & io_y_ready;
  assign push_req   = v[STAGES] & warm;
  assign push       = push_req & (!full | pop);
  assign {io_y_data, io_y_parity} = io_y_valid ? mem[rd[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt         <= '0;
      wr          <= '0;
      rd          <= '0;
      io_overflow <= 1'b0;
    end else begin
      if (!warm) cnt <= cnt + 1'b1;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (push_req & full & !pop) io_overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= {d[STAGES], p[STAGES]};
endmodule

// File: tb/tb_filter_decoder.sv
// tb_filter_decoder: two-stage Filter encoder model feeding filter_decoder, scoreboard-checked
module tb_filter_decoder;
  import filter_pkg::*;
  logic clk, reset;
  logic [15:0] enc_d;
  logic enc_p, enc_v, force_v;
  logic [15:0] e0_d, e1_d;
  logic e0_v, e1_v;
  logic [15:0] io_y_data;
  logic io_y_parity, io_y_valid, io_y_ready, io_overflow;
  logic [2:0] io_level;
  filter_word_t sb [$];
  int checks, failures;
  filter_decoder #(.DATA_W(16), .STAGES(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .io_x_data(e1_d), .io_x_valid(e1_v | force_v), .io_x_parity(e0_d[15]),
    .io_y_data(io_y_data), .io_y_parity(io_y_parity), .io_y_valid(io_y_valid),
    .io_y_ready(io_y_ready), .io_overflow(io_overflow), .io_level(io_level)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Encoder: each stage registers {data<<1, parity_in}, parity_out = its input MSB.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e0_d <= '0;
      e0_v <= 1'b0;
      e1_d <= '0;
      e1_v <= 1'b0;
    end else begin
      e0_d <= {enc_d[14:0], enc_p};
      e0_v <= enc_v;
      e1_d <= {e0_d[14:0], enc_d[15]};
      e1_v <= e0_v;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    filter_word_t w;
    if (io_y_valid && io_y_ready) begin
      if (sb.size() == 0) check("unexpected_word", 32'(sb.size()), 1);
      else begin
        w = sb.pop_front();
        check("y_data", 32'(io_y_data), 32'(w.data));
        check("y_parity", 32'(io_y_parity), 32'(w.parity));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [15:0] d, input logic p, input bit exp);
    enc_d = d;
    enc_p = p;
    enc_v = 1'b1;
    if (exp) sb.push_back('{data: d, parity: p});
    tick();
    enc_v = 1'b0;
  endtask
  task automatic drain(input string tag);
    io_y_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
    check({tag, "_pending"}, 32'(sb.size()), 0);
    check({tag, "_level"}, 32'(io_level), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    checks = 0;
    failures = 0;
    enc_d = '0;
    enc_p = 1'b0;
    enc_v = 1'b0;
    force_v = 1'b0;
    io_y_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(io_y_valid), 0);
    check("rst_level", 32'(io_level), 0);
    check("rst_ovf", 32'(io_overflow), 0);
    check("rst_data", 32'({io_y_data, io_y_parity}), 0);
    // Warm-up: forced chain valid for STAGES+1 cycles must not push.
    reset = 1'b1;
    force_v = 1'b1;
    repeat (3) tick();
    force_v = 1'b0;
    check("warm_level", 32'(io_level), 0);
    check("warm_valid", 32'(io_y_valid), 0);
    send(16'h5A3C, 1'b1, 1);
    drain("warm");
    // Single word latency: visible exactly three cycles after entering the encoder.
    io_y_ready = 1'b1;
    send(16'hA5C3, 1'b1, 1);
    check("lat_t1", 32'(io_y_valid), 0);
    tick();
    check("lat_t2", 32'(io_y_valid), 0);
    tick();
    check("lat_t3", 32'(io_y_valid), 1);
    tick();
    check("lat_t4", 32'(io_y_valid), 0);
    // Back-to-back stream exercises parity carried across neighbouring words.
    send(16'h8001, 1'b0, 1);
    send(16'h7FFE, 1'b1, 1);
    send(16'hFFFF, 1'b1, 1);
    send(16'h0000, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", 32'(io_y_valid), 1);
      tick();
    end
    check("b2b_done", 32'(io_y_valid), 0);
    check("b2b_pending", 32'(sb.size()), 0);
    // Overflow: fifth word into a full FIFO is dropped.
    io_y_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(16'(i), 1'(i), i < 5);
    repeat (3) tick();
    check("ovf_level", 32'(io_level), 4);
    check("ovf_flag", 32'(io_overflow), 1);
    drain("ovf");
    check("ovf_sticky", 32'(io_overflow), 1);
    // Asynchronous reset with words buffered and overflow set.
    io_y_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0F00 + 16'(i), 1'b0, 0);
    repeat (3) tick();
    check("pre_rst_level", 32'(io_level), 3);
    #3 reset = 1'b0;
    #1;
    check("arst_valid", 32'(io_y_valid), 0);
    check("arst_level", 32'(io_level), 0);
    check("arst_ovf", 32'(io_overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    io_y_ready = 1'b1;
    send(16'h1234, 1'b0, 1);
    drain("post_rst");
    // Full FIFO with a pop in the same cycle as a push: accepted, no overflow.
    io_y_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h0100 + 16'(i), 1'(i), 1);
    repeat (3) tick();
    check("full_level", 32'(io_level), 4);
    send(16'hBEEF, 1'b1, 1);
    tick();
    check("full_wait_level", 32'(io_level), 4);
    io_y_ready = 1'b1;
    tick();
    io_y_ready = 1'b0;
    check("swap_level", 32'(io_level), 4);
    check("swap_ovf", 32'(io_overflow), 0);
    drain("swap");
    check("final_valid", 32'(io_y_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/filter_decoder.md
Name: filter_decoder

Overview:
Receiver/decoder for a chain of STAGES Filter stages. Each Filter stage shifts data left one bit, inserts parity at the LSB and emits the shifted-out MSB combinationally as parity. This block sits at the far end of a Filter chain, undoes all STAGES shifts to recover the original word and parity, and buffers the results in a small FIFO with ready/valid output. The Filter chain has no backpressure, so overflow is detected and flagged.

Parameters:
DATA_W, 16, data width; must match the Filter chain.
STAGES, 2, number of chained Filter stages to invert (1..8).
DEPTH, 4, output FIFO entries (power of two, at least 2).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
io_x_data  in  DATA_W  data output of the last Filter stage
io_x_valid  in  1  valid output of the last Filter stage
io_x_parity  in  1  parity output of the last Filter stage (combinational on that stage's input)
io_y_data  out  DATA_W  recovered original word (FIFO head)
io_y_parity  out  1  recovered original parity bit (FIFO head)
io_y_valid  out  1  FIFO non-empty
io_y_ready  in  1  consumer accepts the head this cycle
io_overflow  out  1  sticky: a recovered word was dropped
io_level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; io_y_valid=0, io_y_data=0, io_y_parity=0, io_overflow=0, io_level=0.
  - All unstage parity registers cleared to 0; warm-up counter cleared.
  - Reset asserted mid-operation discards all buffered words immediately.
- Unstage chain: STAGES instances of filter_unstage in series. Instance 0 is fed from the io_x_* inputs and inverts the last Filter stage.
- Each filter_unstage:
  - Register par_q <= parity_in every cycle, independent of valid, because the encoder emits parity one cycle ahead of its data.
  - Combinational outputs: data_out = {par_q, data_in[DATA_W-1:1]}, parity_out = data_in[0], valid_out = valid_in.
- Warm-up:
  - The counter counts up to STAGES+1 after reset release and then holds.
  - Chain valid is ignored until the count is reached. This masks uninitialised encoder registers and stale par_q values.
- FIFO push:
  - Push when chain valid=1 and warm-up is done; the entry is {data, parity}.
  - Latency is 1 cycle: io_x_valid at cycle n gives io_y_valid at n+1 when the FIFO is empty.
  - End to end, a word entering the Filter chain at cycle t appears at io_y at t+STAGES+1.
- FIFO pop: on io_y_valid and io_y_ready.
- Full and push with no pop: drop the word, set io_overflow=1 and hold it until reset. io_level is unchanged.
- Full and push with pop in the same cycle: accept the word. Level stays at DEPTH; no overflow.
- Empty and io_y_ready=1: no effect.
- Empty FIFO: io_y_data and io_y_parity drive 0.
- Pointers wrap modulo DEPTH. io_level = write count minus read count.
- Order is strict FIFO. No word is duplicated or reordered.

Decomposition:
- Package filter_pkg:
  - DATA_W default.
  - Typedef filter_word_t = struct {data[DATA_W], parity}.
  - Function clog2.
- Sub-module filter_unstage (one parity register plus shift/unpack). It is instantiated STAGES times via generate.
- The FIFO stays inline in filter_decoder.

Test Plan:
1. STAGES=2 with two Filter stages in front. Drive 0xA5C3/parity 1 at encoder input at cycle t, io_y_ready=1 -> io_y_valid=1 at t+3 with io_y_data=0xA5C3, io_y_parity=1, then valid drops.
2. Back-to-back encoder stream 0x8001/0, 0x7FFE/1, 0xFFFF/1, 0x0000/0 -> identical four words on four consecutive cycles. This checks cross-word parity alignment.
3. io_y_ready=0, DEPTH=4, five consecutive words 0x0001..0x0005 -> io_level=4 and io_overflow=1. Releasing ready then drains exactly 0x0001..0x0004 in order.
4. FIFO full and ready=1 while a new word arrives -> head pops, new word accepted, io_level stays 4, io_overflow stays 0.
5. Encoder valid forced to 1 during the first STAGES+1 cycles after reset release -> no FIFO push and io_level=0. The first word after warm-up decodes correctly.
6. Assert reset with 3 words buffered and overflow set -> io_y_valid, io_level and io_overflow go to 0 asynchronously. After release, stream 0x1234/0 decodes to 0x1234/0.
